// File: rtl/sram_bank_ctrl.sv
// Bank-decoding controller for NUM_BANKS single-port SRAM macros behind one request port,
// with one aligned read-latency stage and a backpressurable response register.
module sram_bank_ctrl #(
  parameter  int NUM_BANKS      = 2,
  parameter  int WORDS_PER_BANK = 256,
  parameter  int DATA_W         = 32,
  parameter  int ADDR_W         = 9,
  localparam int IDX_W          = $clog2(WORDS_PER_BANK),
  localparam int MASK_W         = DATA_W / 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [MASK_W-1:0]           req_wmask,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [NUM_BANKS-1:0]        sram_csb0,
  output logic                        sram_web0,
  output logic [MASK_W-1:0]           sram_wmask0,
  output logic [IDX_W-1:0]            sram_addr0,
  output logic [DATA_W-1:0]           sram_din0,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_dout0,
  output logic [NUM_BANKS-1:0]        sram_csb1
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holds valid and its payload stable until that edge, ready may depend on valid.

  logic [ADDR_W-1:0] bank_full;
  logic              in_range;
  logic              fire;
  logic              advance;
  logic [DATA_W-1:0] rd_slice;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_we_q,    s1_we_d;
  logic              s1_err_q,   s1_err_d;
  logic [BANK_W-1:0] s1_bank_q,  s1_bank_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign bank_full = req_addr >> IDX_W;
  assign in_range  = bank_full < ADDR_W'(NUM_BANKS);

  // S1 may only be refilled when it drains in the same cycle, which keeps macro dout stable.
  assign advance   = s1_valid_q && (!rsp_valid_q || rsp_ready);
  assign req_ready = !wb_rst_i && (!s1_valid_q || advance);
  assign fire      = req_valid && req_ready;

  assign sram_web0   = ~req_we;
  assign sram_wmask0 = req_wmask;
  assign sram_addr0  = req_addr[IDX_W-1:0];
  assign sram_din0   = req_wdata;
  assign sram_csb1   = '1;

  always_comb begin
    sram_csb0 = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (fire && in_range && (bank_full == ADDR_W'(b))) begin
        sram_csb0[b] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_slice = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (s1_bank_q == BANK_W'(b)) begin
        rd_slice = sram_dout0[b*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_we_d     = s1_we_q;
    s1_err_d    = s1_err_q;
    s1_bank_d   = s1_bank_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    if (fire) begin
      s1_valid_d = 1'b1;
      s1_we_d    = req_we;
      s1_err_d   = !in_range;
      s1_bank_d  = bank_full[BANK_W-1:0];
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = s1_err_q;
      rsp_rdata_d = (s1_we_q || s1_err_q) ? '0 : rd_slice;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_bank_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_we_q     <= s1_we_d;
      s1_err_q    <= s1_err_d;
      s1_bank_q   <= s1_bank_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl with three 256-word banks and a 10-bit address (0x300..0x3FF out of range),
// behavioural macro models, a word-addressed reference memory and a queue-based response scoreboard.
`timescale 1ns/100ps
module tb_sram_bank_ctrl;

  localparam int NB = 3;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LIMIT = NB * 256;

  logic            clk;
  logic            wb_rst_i;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [3:0]      req_wmask;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [NB-1:0]   sram_csb0;
  logic            sram_web0;
  logic [3:0]      sram_wmask0;
  logic [7:0]      sram_addr0;
  logic [DW-1:0]   sram_din0;
  logic [NB*DW-1:0] sram_dout0;
  logic [NB-1:0]   sram_csb1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ref_mem [int];

  logic bp_en = 1'b0;
  logic force_ready = 1'b1;
  logic rnd_ready = 1'b1;
  assign rsp_ready = bp_en ? rnd_ready : force_ready;

  sram_bank_ctrl #(.NUM_BANKS(NB), .WORDS_PER_BANK(256), .DATA_W(DW), .ADDR_W(AW)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wmask(req_wmask),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0), .sram_csb1(sram_csb1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- macro models ----------------
  logic [DW-1:0] mem [NB][256];
  logic [DW-1:0] dout_r [NB];
  assign sram_dout0 = {dout_r[2], dout_r[1], dout_r[0]};

  initial begin
    for (int b = 0; b < NB; b++) begin
      dout_r[b] = '0;
      for (int i = 0; i < 256; i++) mem[b][i] = '0;
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!sram_csb0[b]) begin
        if (!sram_web0) begin
          for (int k = 0; k < 4; k++)
            if (sram_wmask0[k]) mem[b][sram_addr0][k*8 +: 8] <= sram_din0[k*8 +: 8];
        end else begin
          dout_r[b] <= mem[b][sram_addr0];
        end
      end
    end
  end

  always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word-addressed memory with byte-masked writes.
  function automatic logic [DW:0] model(input bit we, input int addr, input logic [DW-1:0] wdata,
                                        input logic [3:0] mask);
    logic [DW-1:0] w;
    if (addr >= LIMIT) return {1'b1, 32'h0};
    w = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
    if (we) begin
      for (int k = 0; k < 4; k++) if (mask[k]) w[k*8 +: 8] = wdata[k*8 +: 8];
      ref_mem[addr] = w;
      return {1'b0, 32'h0};
    end
    return {1'b0, w};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic          held = 1'b0;
  logic [DW:0]   held_val;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (wb_rst_i) begin
        held = 1'b0;
        continue;
      end
      tests_run++;
      if ($countones(~sram_csb0) > 1) begin
        tests_failed++;
        $display("FAIL csb_onehot: csb0=%b", sram_csb0);
      end
      if (held) begin
        check("hold_valid", 64'(rsp_valid), 64'(1));
        check("hold_data", 64'({rsp_err, rsp_rdata}), 64'(held_val));
      end
      if (rsp_valid && rsp_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_rsp: got err=%0b rdata=0x%0h with nothing outstanding", rsp_err, rsp_rdata);
        end else begin
          check("rsp", 64'({rsp_err, rsp_rdata}), 64'(exp_q.pop_front()));
        end
      end else if (rsp_valid) begin
        held = 1'b1;
        held_val = {rsp_err, rsp_rdata};
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic issue(input bit we, input int addr, input logic [DW-1:0] wdata, input logic [3:0] mask);
    int waited = 0;
    logic [NB-1:0] e_csb;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr[AW-1:0];
    req_wdata = wdata;
    req_wmask = mask;
    #1;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready) begin
      check("req_timeout", 64'(0), 64'(1));
      @(negedge clk);
      req_valid = 1'b0;
      return;
    end
    e_csb = '1;
    if (addr < LIMIT) e_csb[addr / 256] = 1'b0;
    check("issue_csb0", 64'(sram_csb0), 64'(e_csb));
    check("issue_addr0", 64'(sram_addr0), 64'(addr % 256));
    check("issue_web0", 64'(sram_web0), 64'(!we));
    exp_q.push_back(model(we, addr, wdata, mask));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int n, input bit hold_valid);
    wb_rst_i  = 1'b1;
    req_valid = hold_valid;
    exp_q.delete();
    repeat (n) begin
      #1;
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_csb0", 64'(sram_csb0), 64'({NB{1'b1}}));
      check("rst_csb1", 64'(sram_csb1), 64'({NB{1'b1}}));
      @(posedge clk);
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      @(negedge clk);
    end
    wb_rst_i  = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || rsp_valid) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  int cnt;
  int pool[8] = '{5, 6, 'h105, 'h106, 'h2FF, 'h200, 'h300, 'h0FF};

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
    wb_rst_i  = 1'b1;

    // Reset held for 3 cycles while a request is presented.
    do_reset(3, 1'b1);
    check("post_rst_rsp_err", 64'(rsp_err), 64'(0));
    check("post_rst_rsp_rdata", 64'(rsp_rdata), 64'(0));

    // Write then back-to-back read of the same word.
    issue(1'b1, 'h005, 32'h0000_00AA, 4'hF);
    issue(1'b0, 'h005, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    check("raw_latency_valid", 64'(rsp_valid), 64'(1));
    check("raw_latency_rdata", 64'(rsp_rdata), 64'(32'h0000_00AA));
    @(negedge clk);
    drain();

    // Bank 1 select and partial-mask merge.
    issue(1'b1, 'h105, 32'h1234_5678, 4'hF);
    issue(1'b1, 'h105, 32'hFFFF_FFFF, 4'b0011);
    issue(1'b0, 'h105, 32'h0, 4'h0);
    drain();

    // Four back-to-back reads with the response side always ready.
    cnt = 0;
    fork
      begin
        issue(1'b0, 'h005, 32'h0, 4'h0);
        issue(1'b0, 'h105, 32'h0, 4'h0);
        issue(1'b0, 'h006, 32'h0, 4'h0);
        issue(1'b0, 'h2FF, 32'h0, 4'h0);
      end
      begin
        repeat (6) begin
          @(negedge clk);
          #3;
          if (rsp_valid) cnt++;
        end
      end
    join
    check("stream_valid_cycles", 64'(cnt), 64'(4));
    drain();

    // Backpressure: fill response and S1, then stall three cycles.
    force_ready = 1'b0;
    issue(1'b0, 'h105, 32'h0, 4'h0);
    issue(1'b0, 'h005, 32'h0, 4'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h006;
    repeat (3) begin
      #1;
      check("bp_req_ready", 64'(req_ready), 64'(0));
      check("bp_csb0", 64'(sram_csb0), 64'({NB{1'b1}}));
      @(negedge clk);
    end
    force_ready = 1'b1;
    issue(1'b0, 'h006, 32'h0, 4'h0);
    drain();

    // Out-of-range access, then the top in-range word.
    issue(1'b1, 'h2FF, 32'hCAFE_F00D, 4'hF);
    issue(1'b0, 'h300, 32'h0, 4'h0);
    issue(1'b0, 'h2FF, 32'h0, 4'h0);
    drain();

    // Reset the cycle after a read is accepted: its response must never appear.
    issue(1'b0, 'h2FF, 32'h0, 4'h0);
    do_reset(1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #2;
      check("midflight_no_rsp", 64'(rsp_valid), 64'(0));
    end
    issue(1'b0, 'h105, 32'h0, 4'h0);
    drain();

    // Randomised traffic with random response backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int a;
      a = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 7)] : int'($urandom_range(0, 1023));
      issue($urandom_range(0, 1) != 0, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    bp_en = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
